// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite blitter: sprite/screen geometry,
// the transparent key color, bus widths and the blit FSM state type.
package sprite_pkg;

  localparam int SPR_W    = 20;
  localparam int SPR_H    = 22;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [23:0] KEY_COLOR = 24'h800080;

  localparam int ROM_ADDR_W = 9;
  localparam int FB_ADDR_W  = 19;
  localparam int COLOR_W    = 24;
  localparam int COORD_W    = 10;
  // One bit wider than a screen coordinate so off-screen sums stay visible.
  localparam int SUM_W      = 11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } blit_state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Row-major sprite pixel counters with horizontal-flip mapping to the ROM
// pixel address; 'last' marks the bottom-right pixel of the sprite.
module sprite_addr_gen #(
  parameter int SPR_W = sprite_pkg::SPR_W,
  parameter int SPR_H = sprite_pkg::SPR_H,
  localparam int X_W  = $clog2(SPR_W),
  localparam int Y_W  = $clog2(SPR_H)
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                clear,
  input  logic                                advance,
  input  logic                                flip,
  output logic [X_W-1:0]                      sx,
  output logic [Y_W-1:0]                      sy,
  output logic [sprite_pkg::ROM_ADDR_W-1:0]   rom_addr,
  output logic                                last
);
  import sprite_pkg::*;

  logic            sx_end;
  logic            sy_end;
  logic [X_W-1:0]  col;

  assign sx_end = (sx == X_W'(SPR_W - 1));
  assign sy_end = (sy == Y_W'(SPR_H - 1));
  assign last   = sx_end && sy_end;

  // Mirroring only changes which ROM column is read; screen columns still
  // advance left to right.
  assign col      = flip ? (X_W'(SPR_W - 1) - sx) : sx;
  assign rom_addr = ROM_ADDR_W'(sy) * ROM_ADDR_W'(SPR_W) + ROM_ADDR_W'(col);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      sx <= '0;
      sy <= '0;
    end else if (advance) begin
      if (sx_end) begin
        sx <= '0;
        sy <= sy_end ? '0 : sy + Y_W'(1);
      end else begin
        sx <= sx + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from a combinational color ROM into the frame buffer,
// with optional horizontal mirroring, key-color transparency and clipping.
module sprite_blitter #(
  parameter int          SPR_W     = sprite_pkg::SPR_W,
  parameter int          SPR_H     = sprite_pkg::SPR_H,
  parameter int          SCREEN_W  = sprite_pkg::SCREEN_W,
  parameter int          SCREEN_H  = sprite_pkg::SCREEN_H,
  parameter logic [23:0] KEY_COLOR = sprite_pkg::KEY_COLOR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        flip,
  output logic        busy,
  output logic        done,
  output logic [8:0]  rom_addr,
  input  logic [23:0] rom_color,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [23:0] fb_data,
  input  logic        fb_ready
);
  import sprite_pkg::*;

  localparam int X_W = $clog2(SPR_W);
  localparam int Y_W = $clog2(SPR_H);

  blit_state_t          state, state_next;
  logic [COORD_W-1:0]   pos_x_q, pos_y_q;
  logic                 flip_q;

  logic [X_W-1:0]       sx;
  logic [Y_W-1:0]       sy;
  logic                 last;

  logic                 slot_free;
  logic                 clear;
  logic                 capture;
  logic                 finish;

  logic [SUM_W-1:0]     x_sum, y_sum;
  logic                 on_screen;
  logic [FB_ADDR_W-1:0] fb_addr_next;

  sprite_addr_gen #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_addr_gen (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (clear),
    .advance  (capture),
    .flip     (flip_q),
    .sx       (sx),
    .sy       (sy),
    .rom_addr (rom_addr),
    .last     (last)
  );

  // The output slot can take a new pixel once the pending write (if any)
  // is being accepted on this edge.
  assign slot_free = !fb_we || fb_ready;

  assign x_sum        = SUM_W'(pos_x_q) + SUM_W'(sx);
  assign y_sum        = SUM_W'(pos_y_q) + SUM_W'(sy);
  assign on_screen    = (x_sum < SUM_W'(SCREEN_W)) && (y_sum < SUM_W'(SCREEN_H));
  assign fb_addr_next = FB_ADDR_W'(y_sum) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(x_sum);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (slot_free) begin
          capture = 1'b1;
          if (last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (slot_free) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      flip_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      done <= finish;
      if (clear) begin
        pos_x_q <= pos_x;
        pos_y_q <= pos_y;
        flip_q  <= flip;
        busy    <= 1'b1;
      end
      if (capture) begin
        fb_data <= rom_color;
        fb_addr <= fb_addr_next;
        fb_we   <= (rom_color != KEY_COLOR) && on_screen;
      end
      if (finish) begin
        fb_we <= 1'b0;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed and randomized blits
// compared against a pixel-list reference model of the sprite copy.
module tb_sprite_blitter;
  import sprite_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic        flip = 1'b0;
  logic        busy, done;
  logic [8:0]  rom_addr;
  logic [23:0] rom_color;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;
  logic        fb_ready = 1'b1;

  sprite_blitter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .flip      (flip),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_color (rom_color),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_ready  (fb_ready)
  );

  always #5 Clk = ~Clk;

  logic [23:0] rom [0:511];
  assign rom_color = rom[rom_addr];

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  bit  rec_en = 1'b0;
  int  stalls = 0;
  int  checks = 0;
  int  passes = 0;
  int  fails  = 0;

  // Frame-buffer side: a write lands on the edge after a cycle with we & ready.
  always @(negedge Clk) begin
    if (rec_en) begin
      if (fb_we && fb_ready) got_q.push_back('{int'(fb_addr), int'(fb_data)});
      if (fb_we && !fb_ready) stalls++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the sprite is a grid of SPR_W x SPR_H pixels placed at (px,py);
  // every visible, non-key pixel becomes one write, scanned row by row.
  task automatic build_expected(input int px, input int py, input bit fl);
    exp_q.delete();
    for (int r = 0; r < SPR_H; r++) begin
      for (int c = 0; c < SPR_W; c++) begin
        int src;
        int x;
        int y;
        src = r * SPR_W + (fl ? (SPR_W - 1 - c) : c);
        x   = px + c;
        y   = py + r;
        if (rom[src] != KEY_COLOR && x < SCREEN_W && y < SCREEN_H)
          exp_q.push_back('{y * SCREEN_W + x, int'(rom[src])});
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
      check({tag, "_data"}, got_q[i].data, exp_q[i].data);
      if (got_q[i].addr != exp_q[i].addr || got_q[i].data != exp_q[i].data) break;
    end
  endtask

  // mode: 0 = fb_ready held high, 1 = toggling, 2 = random.
  task automatic run_blit(input int px, input int py, input bit fl, input int mode,
                          input bit mid_start, input string tag, output int cycles);
    got_q.delete();
    stalls = 0;
    build_expected(px, py, fl);
    @(negedge Clk);
    pos_x    = 10'(px);
    pos_y    = 10'(py);
    flip     = fl;
    fb_ready = 1'b1;
    start    = 1'b1;
    rec_en   = 1'b1;
    @(posedge Clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    check({tag, "_busy_after_start"}, busy, 1);
    while (cycles < 3000) begin
      if (mode == 1) fb_ready = ~fb_ready;
      else if (mode == 2) fb_ready = 1'($urandom_range(0, 1));
      if (mid_start && cycles == 100) begin
        start = 1'b1;
        pos_x = 10'd0;
        pos_y = 10'd0;
        flip  = ~fl;
      end
      if (mid_start && cycles == 101) begin
        start = 1'b0;
        check({tag, "_busy_mid"}, busy, 1);
      end
      @(posedge Clk);
      #1;
      cycles++;
      if (done) break;
    end
    rec_en   = 1'b0;
    fb_ready = 1'b1;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_cycles"}, cycles, 441 + stalls);
    @(posedge Clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    compare_writes(tag);
  endtask

  initial begin
    int cyc;
    int max_addr;

    for (int i = 0; i < 512; i++) rom[i] = (i < 440) ? 24'(i + 1) : 24'h0;

    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_rom_addr", rom_addr, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Straight copy, no stalls.
    run_blit(100, 50, 1'b0, 0, 1'b0, "plain", cyc);
    check("plain_cycles_441", cyc, 441);
    if (got_q.size() == 440) begin
      check("plain_first_addr", got_q[0].addr, 32100);
      check("plain_first_data", got_q[0].data, 1);
      check("plain_last_addr", got_q[439].addr, 45559);
      check("plain_last_data", got_q[439].data, 440);
    end

    // Mirrored copy.
    run_blit(100, 50, 1'b1, 0, 1'b0, "flip", cyc);
    if (got_q.size() > 20) begin
      check("flip_first_addr", got_q[0].addr, 32100);
      check("flip_first_data", got_q[0].data, 20);
      check("flip_row1_data", got_q[20].data, 40);
    end

    // All transparent except pixel 0.
    for (int i = 1; i < 440; i++) rom[i] = KEY_COLOR;
    run_blit(200, 100, 1'b0, 0, 1'b0, "keyed", cyc);
    check("keyed_one_write", got_q.size(), 1);
    check("keyed_cycles_441", cyc, 441);
    for (int i = 0; i < 440; i++) rom[i] = 24'(i + 1);

    // Bottom-right corner clipping.
    run_blit(630, 470, 1'b0, 0, 1'b0, "clip", cyc);
    check("clip_100_writes", got_q.size(), 100);
    max_addr = 0;
    foreach (got_q[i]) if (got_q[i].addr > max_addr) max_addr = got_q[i].addr;
    check("clip_addr_in_range", max_addr < 307200, 1);

    // Back-pressure 1010... with an ignored start mid-blit.
    run_blit(300, 200, 1'b0, 1, 1'b1, "toggle", cyc);
    check("toggle_stalls_seen", stalls > 0, 1);

    // Reset part way through a mirrored blit.
    @(negedge Clk);
    pos_x = 10'd10;
    pos_y = 10'd10;
    flip  = 1'b1;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (200) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("midrst_fb_we", fb_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rom_addr", rom_addr, 0);
    @(negedge Clk);
    Reset = 1'b0;
    run_blit(10, 10, 1'b0, 0, 1'b0, "after_rst", cyc);
    check("after_rst_440", got_q.size(), 440);

    // Randomized sprites, positions near the edges and random back-pressure.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 440; i++)
        rom[i] = ($urandom_range(0, 3) == 0) ? KEY_COLOR : 24'($urandom);
      run_blit(int'($urandom_range(560, 639)), int'($urandom_range(400, 479)),
               1'($urandom_range(0, 1)), 2, 1'b0, "rand", cyc);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
